// File: rtl/pipe_reg_skid_if.sv
// pipe_reg_skid_if -- handshake bundle for the 2-entry skid pipeline register.
//   in_valid/in_ready/in_data    : upstream valid/ready transfer
//   out_valid/out_ready/out_data : downstream valid/ready transfer
//   flush                        : discard all held entries
//   count                        : current occupancy (0..2)
// Modport slave is the pipeline block; master is whoever drives upstream
// data and downstream ready.
interface pipe_reg_skid_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       count;

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid -- 2-entry pipeline register (main + skid) with full
// throughput and registered in_ready.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : pipe_reg_skid_if.slave (handshakes, payload, flush, count)
//
// state  | meaning
// -------+--------------------------------------------------------
// EMPTY  | nothing held, out_valid=0, in_ready=1, count=0
// ONE    | main holds head, out_valid=1, in_ready=1, count=1
// TWO    | main holds head, skid holds next, in_ready=0, count=2
module pipe_reg_skid #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  pipe_reg_skid_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       count_q, count_d;

  logic in_fire;
  logic out_fire;

  // Handshakes use the registered flags so in_ready never depends on out_ready.
  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      // Flush wins over any transfer; data registers keep their contents.
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            main_d  = bus.in_data;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = bus.in_data;
          end else if (in_fire) begin
            skid_d  = bus.in_data;
            state_d = S_TWO;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    // Outputs are registered copies decoded from the next state.
    in_ready_d  = (state_d != S_TWO);
    out_valid_d = (state_d != S_EMPTY);
    case (state_d)
      S_ONE:   count_d = 2'd1;
      S_TWO:   count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_pipe_reg_skid.sv
module tb_pipe_reg_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        flush;
  logic [63:0] data64;

  always #5 clk = ~clk;

  pipe_reg_skid_if #(.WIDTH(32)) if32 ();
  pipe_reg_skid_if #(.WIDTH(8))  if8  ();
  pipe_reg_skid_if #(.WIDTH(64)) if64 ();

  assign if32.in_valid  = in_valid;
  assign if32.out_ready = out_ready;
  assign if32.flush     = flush;
  assign if32.in_data   = data64[31:0];
  assign if8.in_valid   = in_valid;
  assign if8.out_ready  = out_ready;
  assign if8.flush      = flush;
  assign if8.in_data    = data64[7:0];
  assign if64.in_valid  = in_valid;
  assign if64.out_ready = out_ready;
  assign if64.flush     = flush;
  assign if64.in_data   = data64;

  pipe_reg_skid #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  pipe_reg_skid #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  pipe_reg_skid #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of capacity 2 plus the last head value,
  // which is what out_data shows while nothing is held.
  logic [63:0] mq[$];
  logic [63:0] last_head = 64'h0;

  always @(posedge clk) begin
    automatic int  sz   = mq.size();
    automatic bit  pop  = out_ready && (sz > 0);
    automatic bit  push = in_valid && (sz < 2);
    if (!rst) begin
      mq.delete();
      last_head = 64'h0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(data64);
    end
    if (mq.size() > 0) last_head = mq[0];
  end

  always @(negedge clk) begin
    if (started) begin
      automatic int          sz   = mq.size();
      automatic logic [63:0] head = (sz > 0) ? mq[0] : last_head;
      check("w32 out_valid", {63'h0, if32.out_valid}, {63'h0, sz != 0});
      check("w32 count",     {62'h0, if32.count},     64'(sz));
      check("w32 in_ready",  {63'h0, if32.in_ready},  {63'h0, sz < 2});
      check("w32 in_ready_vs_count", {63'h0, if32.in_ready}, {63'h0, if32.count != 2'd2});
      check("w32 out_data",  {32'h0, if32.out_data},  head & 64'hFFFF_FFFF);
      check("w8 count",      {62'h0, if8.count},      64'(sz));
      check("w8 in_ready",   {63'h0, if8.in_ready},   {63'h0, if8.count != 2'd2});
      check("w8 out_valid",  {63'h0, if8.out_valid},  {63'h0, sz != 0});
      check("w8 out_data",   {56'h0, if8.out_data},   head & 64'hFF);
      check("w64 count",     {62'h0, if64.count},     64'(sz));
      check("w64 in_ready",  {63'h0, if64.in_ready},  {63'h0, if64.count != 2'd2});
      check("w64 out_valid", {63'h0, if64.out_valid}, {63'h0, sz != 0});
      check("w64 out_data",  if64.out_data,           head);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Literal expectations for the 32-bit instance, also pinning the model.
  task automatic expect32(input string nm, input int cnt, input logic [31:0] dat);
    check({nm, " count"},     {62'h0, if32.count},     64'(cnt));
    check({nm, " out_valid"}, {63'h0, if32.out_valid}, {63'h0, cnt != 0});
    check({nm, " in_ready"},  {63'h0, if32.in_ready},  {63'h0, cnt != 2});
    check({nm, " out_data"},  {32'h0, if32.out_data},  {32'h0, dat});
    check({nm, " model_cnt"}, 64'(mq.size()),          64'(cnt));
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; data64 = 64'h0;
    step();
    step();
    started = 1'b1;
    rst = 1'b1;
    expect32("reset", 0, 32'h0);
    step();
    expect32("idle", 0, 32'h0);

    // Streaming at full rate.
    out_ready = 1'b1; in_valid = 1'b1;
    data64 = 64'h11; step(); expect32("stream0", 1, 32'h11);
    data64 = 64'h22; step(); expect32("stream1", 1, 32'h22);
    data64 = 64'h33; step(); expect32("stream2", 1, 32'h33);
    in_valid = 1'b0; step(); expect32("stream_drain", 0, 32'h33);

    // Backpressure.
    out_ready = 1'b0; in_valid = 1'b1;
    data64 = 64'hA1; step(); expect32("bp_a1", 1, 32'hA1);
    data64 = 64'hB2; step(); expect32("bp_b2", 2, 32'hA1);
    data64 = 64'hC3; step(); expect32("bp_c3_held", 2, 32'hA1);
    out_ready = 1'b1; step(); expect32("bp_out_b2", 1, 32'hB2);
    step(); expect32("bp_out_c3", 1, 32'hC3);
    in_valid = 1'b0; step(); expect32("bp_empty", 0, 32'hC3);

    // Flush collision.
    out_ready = 1'b0; in_valid = 1'b1;
    data64 = 64'h5; step();
    data64 = 64'h6; step(); expect32("fl_full", 2, 32'h5);
    flush = 1'b1; data64 = 64'h7; step(); expect32("fl_flushed", 0, 32'h5);
    flush = 1'b0; in_valid = 1'b0; step(); expect32("fl_no7", 0, 32'h5);

    // Reset mid-operation.
    in_valid = 1'b1;
    data64 = 64'h8; step();
    data64 = 64'h9; step(); expect32("rm_full", 2, 32'h8);
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b0; step();
    expect32("rm_reset", 0, 32'h0);
    rst = 1'b1; step(); expect32("rm_after", 0, 32'h0);

    // Random stress; checking is done by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) < 2);
      data64    = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step();
    step();
    expect32("final_empty", 0, if32.out_data);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_reg_skid.md
PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 Parameter: WIDTH, 32, data width in bits (legal range 1..256).
REQ-002 Parameter: RESET_VAL, {WIDTH{1'b0}}, value loaded into both data registers on reset.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-low (asserted when 0, sampled on clk rising edge).
REQ-005 Port: in_valid  input  1  upstream holds valid data on in_data.
REQ-006 Port: in_ready  output  1  block can accept a transfer this cycle.
REQ-007 Port: in_data  input  WIDTH  upstream payload.
REQ-008 Port: out_valid  output  1  out_data holds a valid entry.
REQ-009 Port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 Port: out_data  output  WIDTH  head-of-buffer payload.
REQ-011 Port: flush  input  1  discard all held entries.
REQ-012 Port: count  output  2  occupancy, 0..2.

Function
REQ-013 Block SHALL be a 2-entry pipeline register: main register (drives out_data) plus skid register; state EMPTY (count 0), ONE (count 1), TWO (count 2).
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL be a pure function of registered state: 1 in EMPTY/ONE, 0 in TWO; no combinational path from out_ready or in_valid.
REQ-016 out_valid SHALL be 1 exactly in ONE and TWO; out_data SHALL be the main register directly.
REQ-017 EMPTY: input transfer -> main<=in_data, go ONE; otherwise hold.
REQ-018 ONE: in+out transfer -> main<=in_data, stay ONE; in only -> skid<=in_data, go TWO; out only -> go EMPTY; neither -> hold.
REQ-019 TWO: out transfer -> main<=skid, go ONE; otherwise hold; no input transfer possible.
REQ-020 Latency in_data to out_data SHALL be 1 cycle; sustained throughput SHALL be 1 transfer/cycle while out_ready is held 1.
REQ-021 Data order SHALL be strict FIFO; no entry SHALL be duplicated or lost except via flush or reset.
REQ-022 Data registers SHALL update only on the loads listed in REQ-017..019; otherwise hold value (write-enable semantics).
REQ-023 flush=1 SHALL force next state EMPTY, overriding all transfers in that cycle; an input transfer coinciding with flush SHALL be dropped; data registers SHALL hold.
REQ-024 While in EMPTY, out_data SHALL retain its last value; consumers SHALL qualify with out_valid.
REQ-025 count SHALL equal occupancy of the current state, updated with the state.

Reset
REQ-026 With rst=0 at a clk edge: state EMPTY, main=skid=RESET_VAL, out_valid=0, count=0, in_ready=1 from the following cycle.
REQ-027 Reset SHALL take priority over flush and all transfers; reset mid-operation SHALL discard all held entries.
REQ-028 Reset SHALL take effect only at a clk edge; no asynchronous path from rst to any output.

Verification
REQ-029 Reset then idle: rst=0 one cycle, then rst=1 -> out_valid=0, count=0, in_ready=1, out_data=RESET_VAL (0x00000000 at WIDTH=32).
REQ-030 Streaming: out_ready=1, in_valid=1 with data 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each, count stays 1, in_ready never drops.
REQ-031 Backpressure: out_ready=0, push 0xA1 then 0xB2 -> count=2, in_ready=0, 0xC3 held on in_data not accepted; raise out_ready -> outputs 0xA1, 0xB2, 0xC3 in order.
REQ-032 Flush collision: count=2 holding 0x5,0x6, assert flush with in_valid=1 data 0x7 -> next cycle count=0, out_valid=0; 0x7 never appears at output.
REQ-033 Reset mid-operation: count=2, rst=0 with out_ready=1 -> next cycle count=0, out_data=RESET_VAL; no transfer completes during the reset cycle.
REQ-034 Random stress: random in_valid/out_ready/flush (flush 2%), WIDTH=8 and WIDTH=64 -> scoreboard shows in-order, loss-free delivery between flushes; in_ready==(count!=2) every cycle.
